ball_dir_ctrl: RTL and testbench
================================

BALL_DIR_CTRL -- requirements
Module: ball_dir_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: playfield cells per axis.
REQ-002 SHALL have parameter BIT_OF_WIDTH, default 3: coordinate width, log2(WIDTH).
REQ-003 SHALL have parameter PADDLE_LEN, default 3: paddle height in cells.
REQ-004 SHALL have parameter SCORE_MAX, default 7: points that end the game.
REQ-005 SHALL have parameter SERVE_TICKS, default 4: idle ticks after a miss.
REQ-006 clk  in  1  single clock; all state updates on rising edge; outputs stable for a downstream falling-edge sampler.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 tick  in  1  one-cycle ball-step strobe, same rate as the ball position stage.
REQ-009 start  in  1  level; begins a game from IDLE or OVER.
REQ-010 ball_x, ball_y  in  BIT_OF_WIDTH  current ball position from the position stage.
REQ-011 paddle_l, paddle_r  in  BIT_OF_WIDTH  top row of the left (column 0) and right (column WIDTH-1) paddles.
REQ-012 x_dir, y_dir  out  1  0 = increment, 1 = decrement, per axis.
REQ-013 en  out  1  1 = ball moves; 0 = position stage recentres the ball.
REQ-014 endgame  out  1  1 = game over, freezes the position stage.
REQ-015 score_l, score_r  out  BIT_OF_WIDTH  points per player.

Function
REQ-016 SHALL implement FSM IDLE, SERVE, PLAY, MISS, OVER; transitions other than start/reset occur only in cycles with tick=1.
REQ-017 IDLE: en=0, endgame=0; start=1 -> SERVE on the next edge, tick not required.
REQ-018 SERVE: en=0 for exactly one tick, then PLAY with en=1; x_dir toward the player who lost the last point (first serve x_dir=0), y_dir=0.
REQ-019 PLAY, per tick, on the ball_x/ball_y sampled that cycle: y_dir forced 1 when ball_y==WIDTH-1 and y_dir==0; forced 0 when ball_y==0 and y_dir==1.
REQ-020 PLAY left hit: x_dir==1, ball_x==1, paddle_l <= ball_y <= paddle_l+PADDLE_LEN-1 -> x_dir=0.
REQ-021 PLAY right hit: x_dir==0, ball_x==WIDTH-2, paddle_r <= ball_y <= paddle_r+PADDLE_LEN-1 -> x_dir=1.
REQ-022 Paddle range comparisons SHALL use BIT_OF_WIDTH+1-bit arithmetic; no wrap past WIDTH-1.
REQ-023 Corner case: wall and paddle reflections in the same tick SHALL both apply.
REQ-024 Miss: ball_x==0 with x_dir==1 -> score_r+1; ball_x==WIDTH-1 with x_dir==0 -> score_l+1; en=0 and state MISS from the next edge.
REQ-025 MISS: hold en=0 for SERVE_TICKS ticks; then OVER if either score==SCORE_MAX, else SERVE.
REQ-026 OVER: endgame=1, en=0, scores held; start=1 -> scores cleared, endgame=0, SERVE.
REQ-027 Scores SHALL saturate at SCORE_MAX, never wrap.
REQ-028 Direction and score outputs SHALL be registered; a direction change is visible one clk after the deciding tick, before the next tick.
REQ-029 tick while start=1 in IDLE: start takes priority; the tick is ignored.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, x_dir=0, y_dir=0, en=0, endgame=0, score_l=0, score_r=0, MISS tick counter 0, last-loser flag 0.
REQ-031 Reset asserted mid-rally or mid-MISS SHALL discard the point in progress; no score update on the deassertion edge.

Structure
REQ-032 FSM state encoding, SCORE_MAX and SERVE_TICKS defaults SHALL live in a shared pong package used by top level and bench.
REQ-033 Paddle hit test SHALL be one sub-module paddle_hit (inputs: ball_y, paddle top; output: hit), instantiated twice.

Verification
REQ-034 Reset, start=1, one tick -> SERVE; next tick -> PLAY, en=1, x_dir=0, y_dir=0.
REQ-035 PLAY, x_dir=0, ball (6,2), paddle_r=1, tick -> x_dir=1 next cycle, scores unchanged.
REQ-036 PLAY, x_dir=1, ball (0,5), paddle_l=0, tick -> en=0, score_r=1, MISS; after 4 ticks -> SERVE with x_dir=1.
REQ-037 Ball (6,7), x_dir=0, y_dir=0, paddle_r=5, tick -> x_dir=1 and y_dir=1 same cycle.
REQ-038 score_l=6, right miss -> score_l=7; after 4 ticks endgame=1; start=1 -> scores 0, endgame=0.
REQ-039 rst pulsed asynchronously (between edges) during MISS -> outputs at reset values immediately, score unchanged from 0.

Source files
------------

// File: rtl/ball_dir_ctrl_pkg.sv
// Shared pong definitions: FSM state encoding and
// game-length defaults used by RTL and bench.
package ball_dir_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_MISS,
    S_OVER
  } state_t;

  localparam int SCORE_MAX_DEF   = 7;
  localparam int SERVE_TICKS_DEF = 4;

endpackage

// File: rtl/paddle_hit.sv
// Paddle span test: ball row within the paddle,
// evaluated one bit wider so the span never wraps.
module paddle_hit #(
  parameter int BIT_OF_WIDTH = 3,
  parameter int PADDLE_LEN   = 3
) (
  input  logic [BIT_OF_WIDTH-1:0] ball_y,
  input  logic [BIT_OF_WIDTH-1:0] paddle_top,
  output logic                    hit
);

  localparam int EW = BIT_OF_WIDTH + 1;
  localparam logic [EW-1:0] SPAN = EW'(PADDLE_LEN - 1);

  logic [EW-1:0] y_ext;
  logic [EW-1:0] top_ext;
  logic [EW-1:0] bot_ext;

  assign y_ext   = {1'b0, ball_y};
  assign top_ext = {1'b0, paddle_top};
  assign bot_ext = top_ext + SPAN;
  assign hit     = (y_ext >= top_ext) && (y_ext <= bot_ext);

endmodule

// File: rtl/ball_dir_ctrl.sv
// Pong ball direction / rally controller: serve,
// wall and paddle reflection, miss scoring, game over.
module ball_dir_ctrl
  import ball_dir_ctrl_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int PADDLE_LEN   = 3,
  parameter int SCORE_MAX    = SCORE_MAX_DEF,
  parameter int SERVE_TICKS  = SERVE_TICKS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    start,
  input  logic [BIT_OF_WIDTH-1:0] ball_x,
  input  logic [BIT_OF_WIDTH-1:0] ball_y,
  input  logic [BIT_OF_WIDTH-1:0] paddle_l,
  input  logic [BIT_OF_WIDTH-1:0] paddle_r,
  output logic                    x_dir,
  output logic                    y_dir,
  output logic                    en,
  output logic                    endgame,
  output logic [BIT_OF_WIDTH-1:0] score_l,
  output logic [BIT_OF_WIDTH-1:0] score_r
);

  localparam int BW = BIT_OF_WIDTH;
  localparam int CW = 8;
  localparam logic [BW-1:0] X_MAX   = BW'(WIDTH - 1);
  localparam logic [BW-1:0] X_HIT_R = BW'(WIDTH - 2);
  localparam logic [BW-1:0] X_HIT_L = BW'(1);
  localparam logic [BW-1:0] S_MAX   = BW'(SCORE_MAX);
  localparam logic [CW-1:0] C_LAST  = CW'(SERVE_TICKS - 1);

  state_t        state, state_d;
  logic          x_dir_d, y_dir_d, en_d, endgame_d;
  logic [BW-1:0] score_l_d, score_r_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          loser, loser_d;
  logic          hit_l, hit_r;

  paddle_hit #(
    .BIT_OF_WIDTH(BW),
    .PADDLE_LEN  (PADDLE_LEN)
  ) u_hit_l (
    .ball_y    (ball_y),
    .paddle_top(paddle_l),
    .hit       (hit_l)
  );

  paddle_hit #(
    .BIT_OF_WIDTH(BW),
    .PADDLE_LEN  (PADDLE_LEN)
  ) u_hit_r (
    .ball_y    (ball_y),
    .paddle_top(paddle_r),
    .hit       (hit_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      x_dir   <= 1'b0;
      y_dir   <= 1'b0;
      en      <= 1'b0;
      endgame <= 1'b0;
      score_l <= '0;
      score_r <= '0;
      cnt     <= '0;
      loser   <= 1'b0;
    end else begin
      state   <= state_d;
      x_dir   <= x_dir_d;
      y_dir   <= y_dir_d;
      en      <= en_d;
      endgame <= endgame_d;
      score_l <= score_l_d;
      score_r <= score_r_d;
      cnt     <= cnt_d;
      loser   <= loser_d;
    end
  end

  always_comb begin
    state_d   = state;
    x_dir_d   = x_dir;
    y_dir_d   = y_dir;
    en_d      = en;
    endgame_d = endgame;
    score_l_d = score_l;
    score_r_d = score_r;
    cnt_d     = cnt;
    loser_d   = loser;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SERVE;
          x_dir_d   = loser;
          y_dir_d   = 1'b0;
          en_d      = 1'b0;
          score_l_d = '0;
          score_r_d = '0;
        end
      end
      S_SERVE: begin
        if (tick) begin
          state_d = S_PLAY;
          en_d    = 1'b1;
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (!y_dir && ball_y == X_MAX)
            y_dir_d = 1'b1;
          else if (y_dir && ball_y == '0)
            y_dir_d = 1'b0;
          // loser flag doubles as the next serve direction
          if (x_dir && ball_x == '0) begin
            if (score_r != S_MAX)
              score_r_d = score_r + 1'b1;
            loser_d = 1'b1;
            en_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_MISS;
          end else if (!x_dir && ball_x == X_MAX) begin
            if (score_l != S_MAX)
              score_l_d = score_l + 1'b1;
            loser_d = 1'b0;
            en_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_MISS;
          end else if (x_dir && ball_x == X_HIT_L && hit_l) begin
            x_dir_d = 1'b0;
          end else if (!x_dir && ball_x == X_HIT_R && hit_r) begin
            x_dir_d = 1'b1;
          end
        end
      end
      S_MISS: begin
        if (tick) begin
          if (cnt == C_LAST) begin
            cnt_d = '0;
            if (score_l == S_MAX || score_r == S_MAX) begin
              state_d   = S_OVER;
              endgame_d = 1'b1;
            end else begin
              state_d = S_SERVE;
              x_dir_d = loser;
              y_dir_d = 1'b0;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      S_OVER: begin
        if (start) begin
          state_d   = S_SERVE;
          endgame_d = 1'b0;
          score_l_d = '0;
          score_r_d = '0;
          loser_d   = 1'b0;
          x_dir_d   = 1'b0;
          y_dir_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ball_dir_ctrl.sv
// Directed scoreboard bench for ball_dir_ctrl:
// serve, reflections, misses, game over, async reset.
module tb_ball_dir_ctrl;
  import ball_dir_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [2:0] ball_x = '0;
  logic [2:0] ball_y = '0;
  logic [2:0] paddle_l = '0;
  logic [2:0] paddle_r = '0;
  logic       x_dir, y_dir, en, endgame;
  logic [2:0] score_l, score_r;

  typedef struct {
    string      tag;
    logic       xd;
    logic       yd;
    logic       en;
    logic       eg;
    logic [2:0] sl;
    logic [2:0] sr;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail = 0;

  ball_dir_ctrl #(
    .WIDTH       (8),
    .BIT_OF_WIDTH(3),
    .PADDLE_LEN  (3),
    .SCORE_MAX   (SCORE_MAX_DEF),
    .SERVE_TICKS (SERVE_TICKS_DEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .start   (start),
    .ball_x  (ball_x),
    .ball_y  (ball_y),
    .paddle_l(paddle_l),
    .paddle_r(paddle_r),
    .x_dir   (x_dir),
    .y_dir   (y_dir),
    .en      (en),
    .endgame (endgame),
    .score_l (score_l),
    .score_r (score_r)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic xd,
                      input logic yd, input logic e,
                      input logic eg, input logic [2:0] sl,
                      input logic [2:0] sr);
    exp_t x;
    x.tag = tag; x.xd = xd; x.yd = yd;
    x.en = e; x.eg = eg; x.sl = sl; x.sr = sr;
    q.push_back(x);
  endtask

  task automatic chk1(input string tag, input string f,
                      input logic [2:0] act,
                      input logic [2:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0d expected=%0d",
             tag, f, act, exp);
    end
  endtask

  task automatic check();
    exp_t x;
    n_assert++;
    assert (q.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end
    if (q.size() > 0) begin
      x = q.pop_front();
      chk1(x.tag, "x_dir", {2'b0, x_dir}, {2'b0, x.xd});
      chk1(x.tag, "y_dir", {2'b0, y_dir}, {2'b0, x.yd});
      chk1(x.tag, "en", {2'b0, en}, {2'b0, x.en});
      chk1(x.tag, "endgame", {2'b0, endgame}, {2'b0, x.eg});
      chk1(x.tag, "score_l", score_l, x.sl);
      chk1(x.tag, "score_r", score_r, x.sr);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic ball(input logic [2:0] x, input logic [2:0] y);
    ball_x = x;
    ball_y = y;
  endtask

  initial begin
    #12;
    push("reset", 0, 0, 0, 0, 0, 0);
    check();
    rst = 1'b0;
    cyc();

    // start with a simultaneous tick: start wins
    start = 1'b1; tick = 1'b1;
    push("serve", 0, 0, 0, 0, 0, 0);
    cyc();
    start = 1'b0; tick = 1'b0;
    check();

    push("play", 0, 0, 1, 0, 0, 0);
    do_tick(); check();

    ball(6, 2); paddle_r = 1;
    push("hit_r", 1, 0, 1, 0, 0, 0);
    do_tick(); check();

    ball(1, 5); paddle_l = 0;
    push("pass_l", 1, 0, 1, 0, 0, 0);
    do_tick(); check();

    ball(3, 7);
    push("wall_top", 1, 1, 1, 0, 0, 0);
    do_tick(); check();

    ball(0, 5);
    push("miss_l", 1, 1, 0, 0, 0, 1);
    do_tick(); check();

    repeat (3) do_tick();
    push("miss_hold", 1, 1, 0, 0, 0, 1);
    check();
    push("serve_loser", 1, 0, 0, 0, 0, 1);
    do_tick(); check();
    push("play2", 1, 0, 1, 0, 0, 1);
    do_tick(); check();

    ball(1, 1);
    push("hit_l", 0, 0, 1, 0, 0, 1);
    do_tick(); check();

    ball(6, 7); paddle_r = 5;
    push("corner", 1, 1, 1, 0, 0, 1);
    do_tick(); check();

    ball(3, 0);
    push("wall_bot", 1, 0, 1, 0, 0, 1);
    do_tick(); check();

    ball(1, 0); paddle_l = 6;
    push("no_wrap", 1, 0, 1, 0, 0, 1);
    do_tick(); check();

    ball(1, 7); paddle_l = 7;
    push("pad_edge", 0, 1, 1, 0, 0, 1);
    do_tick(); check();

    ball(7, 3);
    for (int i = 1; i <= 7; i++) begin
      push("miss_r", 0, (i == 1) ? 1'b1 : 1'b0, 0, 0,
           3'(i), 1);
      do_tick(); check();
      repeat (4) do_tick();
      if (i < 7) do_tick();
    end
    push("over", 0, 0, 0, 1, 7, 1);
    check();

    push("over_hold", 0, 0, 0, 1, 7, 1);
    do_tick(); check();

    start = 1'b1;
    push("restart", 0, 0, 0, 0, 0, 0);
    cyc();
    start = 1'b0;
    check();

    push("play3", 0, 0, 1, 0, 0, 0);
    do_tick(); check();
    push("miss_r2", 0, 0, 0, 0, 1, 0);
    do_tick(); check();
    do_tick();

    #2 rst = 1'b1;
    #1;
    push("rst_async", 0, 0, 0, 0, 0, 0);
    check();
    #1 rst = 1'b0;
    repeat (3) do_tick();
    push("post_rst", 0, 0, 0, 0, 0, 0);
    check();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
